alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the processor datapath. Computes one of nine arithmetic, shift, logic or compare operations on two operands, selected by a 6-bit opcode.
- The result is computed combinationally and registered, so the block presents a clean registered output to downstream datapath stages.

Parameters:
- DATA_WIDTH, 32, operand and result width (shared constant; DATA_INDEX_LIMIT = DATA_WIDTH-1).
- ALU_OPRN_WIDTH, 6, opcode width (shared constant; ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH-1).

Ports:
- CLK  input  1  system clock; rising edge active.
- RST  input  1  asynchronous, active-low reset.
- op1  input  32  operand 1.
- op2  input  32  operand 2.
- oprn  input  6  operation select.
- result  output  32  registered operation result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- RST low forces result to 32'h0 immediately, independent of CLK. result holds 0 while RST is low.
- Latency: result reflects (op1, op2, oprn) as sampled at a CLK rising edge, valid after that edge. Latency is 1 cycle.
- Throughput: one operation per cycle. No handshake; inputs are sampled every edge.
- Reset release: the first edge with RST high loads a computed result.
- Opcodes (all arithmetic modulo 2^32, two's complement, no flags, no overflow trap):
  - 0x01 add: op1 + op2.
  - 0x02 sub: op1 - op2.
  - 0x03 mul: low 32 bits of op1 * op2. Signed and unsigned give identical low bits.
  - 0x04 shift right logical: op1 >> op2. Zero-fill; the full 32-bit op2 is the shift amount; amount >= 32 gives 0.
  - 0x05 shift left logical: op1 << op2. Same amount rules as 0x04.
  - 0x06 and: op1 & op2.
  - 0x07 or: op1 | op2.
  - 0x08 nor: ~(op1 | op2).
  - 0x09 set-less-than: result = 32'h1 if op1 < op2 as signed 32-bit values, else 32'h0.
- Any other opcode, including 0x00 and 0x0A-0x3F: result = 32'h0 on the next edge.
- Inputs containing X/Z: no defined behaviour required. The bench drives known values only.

Decomposition:
- Shared definitions package/include holds DATA_WIDTH, DATA_INDEX_LIMIT, ALU_OPRN_WIDTH, ALU_OPRN_INDEX_LIMIT, and named opcode constants ALU_OPRN_ADD=0x01 through ALU_OPRN_SLT=0x09.
- One sub-module is natural: alu_core. It is purely combinational: op1, op2, oprn in; next_result out, containing the opcode decode and operations.
- alu wraps alu_core with the asynchronous-reset output register.

Test Plan:
- Reset: RST=0 mid-operation with result nonzero -> result = 0 immediately without a clock edge; it stays 0 until the first edge after RST=1.
- Add/sub: 15+3 -> 18; 15-5 -> 10; 15+(-5) -> 10; 5-15 -> 0xFFFFFFF6. Also 0xFFFFFFFF+1 -> 0 (wrap). Each is checked one cycle after the inputs are applied.
- Multiply: 7*3 -> 21; 7*(-3) -> 0xFFFFFFEB; 0x10000*0x10000 -> 0 (truncation).
- Shifts: 7>>2 -> 1; 7<<2 -> 28; 0x80000000>>31 -> 1 (logical, zero-fill); 1<<32 -> 0.
- Logic: 7&3 -> 3; 7|8 -> 15; ~(8|7) -> 0xFFFFFFF0.
- Set-less-than and illegal opcode: 15<5 -> 0; -1<5 -> 1; 1<5 -> 1; 5<-1 -> 0; -2<-1 -> 1. Opcode 0x00 or 0x3F with any operands -> 0.
- Back-to-back: change opcode every cycle -> each result appears exactly one edge after its inputs.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared widths and opcode encodings for the datapath ALU.
//   DATA_WIDTH / DATA_INDEX_LIMIT       : operand and result width
//   ALU_OPRN_WIDTH / ALU_OPRN_INDEX_LIMIT : opcode width
//   ALU_OPRN_*                          : named opcode values
package alu_pkg;

    localparam int DATA_WIDTH           = 32;
    localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
    localparam int ALU_OPRN_WIDTH       = 6;
    localparam int ALU_OPRN_INDEX_LIMIT = ALU_OPRN_WIDTH - 1;

    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_ADD = 6'h01;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SUB = 6'h02;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_MUL = 6'h03;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SRL = 6'h04;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLL = 6'h05;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_AND = 6'h06;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_OR  = 6'h07;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_NOR = 6'h08;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLT = 6'h09;

endpackage

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational opcode decode and operation datapath.
//   op1, op2    : operands
//   oprn        : operation select
//   next_result : value to be registered on the next clock edge
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_INDEX_LIMIT:0]     op1,
    input  logic [DATA_INDEX_LIMIT:0]     op2,
    input  logic [ALU_OPRN_INDEX_LIMIT:0] oprn,
    output logic [DATA_INDEX_LIMIT:0]     next_result
);

    always_comb begin
        next_result = '0;
        case (oprn)
            ALU_OPRN_ADD: next_result = op1 + op2;
            ALU_OPRN_SUB: next_result = op1 - op2;
            // Low half of the product is the same for signed and unsigned.
            ALU_OPRN_MUL: next_result = op1 * op2;
            // The full 32-bit amount is used, so amounts >= 32 yield zero.
            ALU_OPRN_SRL: next_result = op1 >> op2;
            ALU_OPRN_SLL: next_result = op1 << op2;
            ALU_OPRN_AND: next_result = op1 & op2;
            ALU_OPRN_OR:  next_result = op1 | op2;
            ALU_OPRN_NOR: next_result = ~(op1 | op2);
            ALU_OPRN_SLT: next_result = ($signed(op1) < $signed(op2)) ?
                                        {{DATA_INDEX_LIMIT{1'b0}}, 1'b1} : '0;
            default:      next_result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu
//   32-bit datapath ALU with a registered result (1-cycle latency).
//   CLK    : system clock, rising edge
//   RST    : asynchronous active-low reset, clears result
//   op1    : operand 1
//   op2    : operand 2
//   oprn   : operation select
//   result : registered operation result
module alu
    import alu_pkg::*;
(
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_INDEX_LIMIT:0]     op1,
    input  logic [DATA_INDEX_LIMIT:0]     op2,
    input  logic [ALU_OPRN_INDEX_LIMIT:0] oprn,
    output logic [DATA_INDEX_LIMIT:0]     result
);

    logic [DATA_INDEX_LIMIT:0] next_result;

    alu_core u_core (
        .op1         (op1),
        .op2         (op2),
        .oprn        (oprn),
        .next_result (next_result)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result <= '0;
        end else begin
            result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [5:0]  oprn;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    alu dut (
        .CLK    (clk),
        .RST    (rst),
        .op1    (op1),
        .op2    (op2),
        .oprn   (oprn),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  oprn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [0:27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{"add_15_3",    6'h01, 32'd15,         32'd3,          32'd18};
        vecs[1]  = '{"sub_15_5",    6'h02, 32'd15,         32'd5,          32'd10};
        vecs[2]  = '{"add_15_m5",   6'h01, 32'd15,         32'hFFFF_FFFB,  32'd10};
        vecs[3]  = '{"sub_5_15",    6'h02, 32'd5,          32'd15,         32'hFFFF_FFF6};
        vecs[4]  = '{"add_wrap",    6'h01, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[5]  = '{"mul_7_3",     6'h03, 32'd7,          32'd3,          32'd21};
        vecs[6]  = '{"mul_7_m3",    6'h03, 32'd7,          32'hFFFF_FFFD,  32'hFFFF_FFEB};
        vecs[7]  = '{"mul_trunc",   6'h03, 32'h0001_0000,  32'h0001_0000,  32'd0};
        vecs[8]  = '{"srl_7_2",     6'h04, 32'd7,          32'd2,          32'd1};
        vecs[9]  = '{"sll_7_2",     6'h05, 32'd7,          32'd2,          32'd28};
        vecs[10] = '{"srl_msb_31",  6'h04, 32'h8000_0000,  32'd31,         32'd1};
        vecs[11] = '{"sll_1_32",    6'h05, 32'd1,          32'd32,         32'd0};
        vecs[12] = '{"srl_big_amt", 6'h04, 32'hFFFF_FFFF,  32'h0000_0100,  32'd0};
        vecs[13] = '{"and_7_3",     6'h06, 32'd7,          32'd3,          32'd3};
        vecs[14] = '{"or_7_8",      6'h07, 32'd7,          32'd8,          32'd15};
        vecs[15] = '{"nor_8_7",     6'h08, 32'd8,          32'd7,          32'hFFFF_FFF0};
        vecs[16] = '{"slt_15_5",    6'h09, 32'd15,         32'd5,          32'd0};
        vecs[17] = '{"slt_m1_5",    6'h09, 32'hFFFF_FFFF,  32'd5,          32'd1};
        vecs[18] = '{"slt_1_5",     6'h09, 32'd1,          32'd5,          32'd1};
        vecs[19] = '{"slt_5_m1",    6'h09, 32'd5,          32'hFFFF_FFFF,  32'd0};
        vecs[20] = '{"slt_m2_m1",   6'h09, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd1};
        vecs[21] = '{"slt_eq",      6'h09, 32'd5,          32'd5,          32'd0};
        vecs[22] = '{"ill_00",      6'h00, 32'd15,         32'd5,          32'd0};
        vecs[23] = '{"add_again",   6'h01, 32'd100,        32'd23,         32'd123};
        vecs[24] = '{"ill_3f",      6'h3F, 32'hFFFF_FFFF,  32'd1,          32'd0};
        vecs[25] = '{"or_hi",       6'h07, 32'hA5A5_0000,  32'h0000_5A5A,  32'hA5A5_5A5A};
        vecs[26] = '{"ill_0a",      6'h0A, 32'd7,          32'd3,          32'd0};
        vecs[27] = '{"nor_zero",    6'h08, 32'd0,          32'd0,          32'hFFFF_FFFF};

        // Reset asserted from time zero: result must be 0 without any edge.
        rst  = 1'b0;
        op1  = 32'd15;
        op2  = 32'd3;
        oprn = 6'h01;
        #1;
        check("reset_initial", result, 32'd0);
        @(posedge clk); #1;
        check("reset_held_edge", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_release_no_edge", result, 32'd0);
        @(posedge clk); #1;
        check("first_edge_after_reset", result, 32'd18);

        // Back-to-back: a new vector every cycle; before each edge the
        // previous result must still be held, after it the new one appears.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i > 0) check({"hold_", vecs[i-1].name}, result, vecs[i-1].exp);
            op1  = vecs[i].a;
            op2  = vecs[i].b;
            oprn = vecs[i].oprn;
            @(posedge clk); #1;
            check(vecs[i].name, result, vecs[i].exp);
        end

        // Mid-cycle async reset with a nonzero result.
        @(negedge clk);
        op1  = 32'd7;
        op2  = 32'd8;
        oprn = 6'h07;
        @(posedge clk); #1;
        check("pre_reset_value", result, 32'd15);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_immediate", result, 32'd0);
        @(posedge clk); #1;
        check("async_reset_held", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_release_no_edge", result, 32'd0);
        @(posedge clk); #1;
        check("async_first_edge", result, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
